// File: rtl/pulse_train_checker_pkg.sv
// Shared types for the pulse-train checker: FSM state encoding and small helpers.
package pulse_train_checker_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   function automatic logic is_locked(input state_t s);
      return (s == ST_LOCKED);
   endfunction

endpackage

// File: rtl/pulse_train_checker_if.sv
// Checker bus: generator observation inputs plus registered status outputs.
interface pulse_train_checker_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned PH_W  = 2
);

   logic             cnt;
   logic             tick;
   logic             clear;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] tick_count;
   logic [PH_W-1:0]  phase;

   modport master (
      output cnt, tick, clear,
      input  locked, err, tick_count, phase
   );

   modport slave (
      input  cnt, tick, clear,
      output locked, err, tick_count, phase
   );

endinterface

// File: rtl/pulse_train_checker_mod_n_counter.sv
// Enabled mod-N counter with synchronous load-to-zero; tracks the generator phase.
module mod_n_counter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en) begin
         count <= (count == W'(N - 1)) ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/pulse_train_checker.sv
// Locks onto a mod-PERIOD terminal-count stream and flags deviations after lock.
module pulse_train_checker
   import pulse_train_checker_pkg::*;
#(
   parameter int unsigned PERIOD     = 4,
   parameter int unsigned SYNC_TICKS = 2,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   pulse_train_checker_if.slave  bus
);

   localparam int unsigned PH_W = $clog2(PERIOD);
   localparam int unsigned SC_W = $clog2(SYNC_TICKS + 1);

   state_t           state, state_nxt;
   logic [SC_W-1:0]  sync_cnt, sync_nxt;
   logic [CNT_W-1:0] tc, tc_nxt;
   logic             err, err_nxt;
   logic             locked_q;
   logic [PH_W-1:0]  phase;
   logic             phase_en, phase_load;
   logic             expected;

   assign expected = (phase == PH_W'(PERIOD - 1));

   mod_n_counter #(
      .N (PERIOD),
      .W (PH_W)
   ) u_phase (
      .clock (clock),
      .reset (reset),
      .en    (phase_en),
      .load  (phase_load),
      .count (phase)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_HUNT;
         sync_cnt <= '0;
         tc       <= '0;
         err      <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         sync_cnt <= sync_nxt;
         tc       <= tc_nxt;
         err      <= err_nxt;
         locked_q <= is_locked(state_nxt);
      end
   end

   always_comb begin
      state_nxt  = state;
      sync_nxt   = sync_cnt;
      tc_nxt     = tc;
      err_nxt    = err;
      phase_load = 1'b0;
      phase_en   = 1'b0;
      // clear outranks any transition, including a same-cycle mismatch
      if (bus.clear) begin
         state_nxt  = ST_HUNT;
         sync_nxt   = '0;
         tc_nxt     = '0;
         err_nxt    = 1'b0;
         phase_load = 1'b1;
      end else if (bus.cnt) begin
         unique case (state)
            ST_HUNT: begin
               if (bus.tick) begin
                  state_nxt  = ST_SYNC;
                  sync_nxt   = '0;
                  phase_load = 1'b1;
               end
            end
            ST_SYNC: begin
               phase_en = 1'b1;
               if (bus.tick != expected) begin
                  state_nxt = ST_HUNT;
               end else if (bus.tick) begin
                  sync_nxt = sync_cnt + SC_W'(1);
                  if (sync_cnt == SC_W'(SYNC_TICKS - 1)) begin
                     state_nxt = ST_LOCKED;
                  end
               end
            end
            ST_LOCKED: begin
               phase_en = 1'b1;
               if (bus.tick != expected) begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_HUNT;
               end else if (bus.tick && (tc != '1)) begin
                  tc_nxt = tc + CNT_W'(1);
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end
   end

   assign bus.locked     = locked_q;
   assign bus.err        = err;
   assign bus.tick_count = tc;
   assign bus.phase      = phase;

endmodule
